// File: rtl/wr_port_arbiter_8_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Port count, wavefront-ID width and select width match the downstream wfid mux.
package wr_port_arbiter_8_pkg;

  localparam int NUM_PORTS = 8;
  localparam int WFID_W    = 6;
  localparam int SEL_W     = 16;
  localparam int IDX_W     = 3;
  localparam int CNT_W     = 4;

  // Port 0 gets first priority after reset because the scan starts at last_grant+1.
  localparam logic [IDX_W-1:0] LAST_GRANT_RST = 3'd7;

  typedef struct packed {
    logic [WFID_W-1:0] wfid;
    logic              done;
  } wr_entry_t;

  function automatic logic [CNT_W-1:0] popcount8(input logic [NUM_PORTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/wr_port_arbiter_8_rr.sv
// Combinational round-robin picker: first requesting port scanning upward
// from last_grant+1 (mod 8); the previous winner is considered last.
module rr_arbiter_8
  import wr_port_arbiter_8_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = last_grant + IDX_W'(i);
      if (!any_valid && req[cand]) begin
        any_valid = 1'b1;
        grant_idx = cand;
      end
    end
    if (any_valid) begin
      grant = NUM_PORTS'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/wr_port_arbiter_8.sv
// Write-port source arbiter: one-entry holding buffer per functional-unit port,
// one registered one-hot grant per cycle, round-robin across full buffers.
module wr_port_arbiter_8
  import wr_port_arbiter_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              req_2,
  input  logic              req_3,
  input  logic              req_4,
  input  logic              req_5,
  input  logic              req_6,
  input  logic              req_7,
  input  logic [WFID_W-1:0] req_wfid_0,
  input  logic [WFID_W-1:0] req_wfid_1,
  input  logic [WFID_W-1:0] req_wfid_2,
  input  logic [WFID_W-1:0] req_wfid_3,
  input  logic [WFID_W-1:0] req_wfid_4,
  input  logic [WFID_W-1:0] req_wfid_5,
  input  logic [WFID_W-1:0] req_wfid_6,
  input  logic [WFID_W-1:0] req_wfid_7,
  input  logic              req_done_0,
  input  logic              req_done_1,
  input  logic              req_done_2,
  input  logic              req_done_3,
  input  logic              req_done_4,
  input  logic              req_done_5,
  input  logic              req_done_6,
  input  logic              req_done_7,
  output logic              ready_0,
  output logic              ready_1,
  output logic              ready_2,
  output logic              ready_3,
  output logic              ready_4,
  output logic              ready_5,
  output logic              ready_6,
  output logic              ready_7,
  input  logic              wr_stall,
  output logic [SEL_W-1:0]  wr_port_select,
  output logic [WFID_W-1:0] wfid_0,
  output logic [WFID_W-1:0] wfid_1,
  output logic [WFID_W-1:0] wfid_2,
  output logic [WFID_W-1:0] wfid_3,
  output logic [WFID_W-1:0] wfid_4,
  output logic [WFID_W-1:0] wfid_5,
  output logic [WFID_W-1:0] wfid_6,
  output logic [WFID_W-1:0] wfid_7,
  output logic              wfid_done_0,
  output logic              wfid_done_1,
  output logic              wfid_done_2,
  output logic              wfid_done_3,
  output logic              wfid_done_4,
  output logic              wfid_done_5,
  output logic              wfid_done_6,
  output logic              wfid_done_7,
  output logic [CNT_W-1:0]  pending_cnt
);

  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] done_in;
  logic [WFID_W-1:0]    wfid_in [NUM_PORTS];

  logic [NUM_PORTS-1:0] full_reg;
  logic [NUM_PORTS-1:0] full_next;
  wr_entry_t            data_reg [NUM_PORTS];
  logic [IDX_W-1:0]     last_grant_reg;
  logic [SEL_W-1:0]     sel_reg;
  logic [CNT_W-1:0]     pending_cnt_reg;

  logic [NUM_PORTS-1:0] capture;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_full;
  logic                 grant_en;

  assign req_vec = {req_7, req_6, req_5, req_4, req_3, req_2, req_1, req_0};
  assign done_in = {req_done_7, req_done_6, req_done_5, req_done_4,
                    req_done_3, req_done_2, req_done_1, req_done_0};
  assign wfid_in[0] = req_wfid_0;
  assign wfid_in[1] = req_wfid_1;
  assign wfid_in[2] = req_wfid_2;
  assign wfid_in[3] = req_wfid_3;
  assign wfid_in[4] = req_wfid_4;
  assign wfid_in[5] = req_wfid_5;
  assign wfid_in[6] = req_wfid_6;
  assign wfid_in[7] = req_wfid_7;

  rr_arbiter_8 u_rr (
    .req        (full_reg),
    .last_grant (last_grant_reg),
    .grant      (grant_oh),
    .grant_idx  (grant_idx),
    .any_valid  (any_full)
  );

  assign grant_en = any_full && !wr_stall;

  // Capture only into empty buffers; grant only from full ones, so the two
  // never collide on the same port within a cycle.
  assign capture   = req_vec & ~full_reg;
  assign full_next = (full_reg & ~(grant_en ? grant_oh : '0)) | capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg        <= '0;
      last_grant_reg  <= LAST_GRANT_RST;
      sel_reg         <= '0;
      pending_cnt_reg <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      full_reg        <= full_next;
      pending_cnt_reg <= popcount8(full_next);
      // Data is left in place after a grant so the mux still sees it while select is shown.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (capture[i]) begin
          data_reg[i] <= '{wfid: wfid_in[i], done: done_in[i]};
        end
      end
      if (grant_en) begin
        sel_reg        <= {{(SEL_W-NUM_PORTS){1'b0}}, grant_oh};
        last_grant_reg <= grant_idx;
      end else begin
        sel_reg <= '0;
      end
    end
  end

  assign wr_port_select = sel_reg;
  assign pending_cnt    = pending_cnt_reg;

  assign {ready_7, ready_6, ready_5, ready_4,
          ready_3, ready_2, ready_1, ready_0} = ~full_reg;

  assign wfid_0 = data_reg[0].wfid;
  assign wfid_1 = data_reg[1].wfid;
  assign wfid_2 = data_reg[2].wfid;
  assign wfid_3 = data_reg[3].wfid;
  assign wfid_4 = data_reg[4].wfid;
  assign wfid_5 = data_reg[5].wfid;
  assign wfid_6 = data_reg[6].wfid;
  assign wfid_7 = data_reg[7].wfid;

  assign wfid_done_0 = data_reg[0].done;
  assign wfid_done_1 = data_reg[1].done;
  assign wfid_done_2 = data_reg[2].done;
  assign wfid_done_3 = data_reg[3].done;
  assign wfid_done_4 = data_reg[4].done;
  assign wfid_done_5 = data_reg[5].done;
  assign wfid_done_6 = data_reg[6].done;
  assign wfid_done_7 = data_reg[7].done;

endmodule
